// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier.
// The slave modport is the multiplier; the master modport is the producer/consumer side.
interface shift_add_multiplier_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   inData_A;
  logic [DATA_WIDTH-1:0]   inData_B;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] outData;

  modport slave (
    input  in_valid, inData_A, inData_B, out_ready,
    output in_ready, out_valid, outData
  );

  modport master (
    output in_valid, inData_A, inData_B, out_ready,
    input  in_ready, out_valid, outData
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per cycle,
// fixed DATA_WIDTH-cycle latency, valid/ready handshake on both sides.
module shift_add_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [PW-1:0]         mcand_q,    mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q,   mplier_d;
  logic [PW-1:0]         acc_q,      acc_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [PW-1:0]         out_data_q, out_data_d;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {{DATA_WIDTH{1'b0}}, bus.inData_A};
          mplier_d = bus.inData_B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Product is latched separately so outData survives the next accept clearing acc.
        if (count_q == LAST) begin
          out_data_d = acc_d;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.outData   = out_data_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner cases plus
// randomized streams scored against plain A*B arithmetic.
module tb_shift_add_multiplier;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.DATA_WIDTH(DW)) bus ();

  shift_add_multiplier #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*DW-1:0];
  endfunction

  // Presents one operand pair, waits for acceptance, then counts edges until out_valid.
  task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
    int w;
    w = 0;
    bus.inData_A = a;
    bus.inData_B = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.outData !== '0) begin bad++; $display("FAIL reset_outData got=%h want=0000", bus.outData); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    drive_op(8'd13, 8'd11, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
    total++; if (bus.outData !== 16'h008F) begin bad++; $display("FAIL basic_product got=%h want=008f", bus.outData); end
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_back got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_drop got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_corners();
    logic [DW-1:0] av [3] = '{8'd255, 8'd0, 8'd200};
    logic [DW-1:0] bv [3] = '{8'd255, 8'd200, 8'd0};
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(av[i], bv[i], lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL corner%0d_latency got=%0d want=8", i, lat); end
      total++; if (bus.outData !== ref_mul(av[i], bv[i])) begin bad++; $display("FAIL corner%0d_product got=%h want=%h", i, bus.outData, ref_mul(av[i], bv[i])); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    drive_op(8'd3, 8'd7, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
    bus.inData_A = 8'd9;
    bus.inData_B = 8'd9;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.outData !== 16'h0015) begin bad++; $display("FAIL bp_hold_data got=%h want=0015", bus.outData); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", bus.in_ready); end
    total++; if (bus.outData !== 16'h0015) begin bad++; $display("FAIL bp_data_persist got=%h want=0015", bus.outData); end
  endtask

  task automatic test_reset_midop();
    int lat;
    bus.inData_A = 8'd77;
    bus.inData_B = 8'd99;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.outData !== '0) begin bad++; $display("FAIL midrst_outData got=%h want=0000", bus.outData); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive_op(8'd2, 8'd9, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL midrst_next_latency got=%0d want=8", lat); end
    total++; if (bus.outData !== 16'h0012) begin bad++; $display("FAIL midrst_next_product got=%h want=0012", bus.outData); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   a, b;
    logic [2*DW-1:0] od;
    logic            acc_now, out_now;
    int sent, got, cyc, last_out;
    sent = 0; got = 0; cyc = 0; last_out = -1;
    a = DW'($urandom); b = DW'($urandom);
    bus.inData_A = a; bus.inData_B = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (got < 100 && cyc < 2000) begin
      acc_now = bus.in_valid && bus.in_ready;
      out_now = bus.out_valid && bus.out_ready;
      od = bus.outData;
      tick();
      cyc++;
      if (acc_now) begin
        exp_q.push_back(ref_mul(a, b));
        sent++;
        a = DW'($urandom); b = DW'($urandom);
        bus.inData_A = a; bus.inData_B = b;
        bus.in_valid = (sent < 100);
      end
      if (out_now) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_unexpected_output got=%h want=none", od); end
        else if (od !== exp_q[0]) begin bad++; $display("FAIL b2b_product got=%h want=%h", od, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_out >= 0) begin
          total++; if (cyc - last_out !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d want=10", cyc - last_out); end
        end
        last_out = cyc;
        got++;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (got !== 100) begin bad++; $display("FAIL b2b_count got=%0d want=100", got); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   a, b;
    logic [2*DW-1:0] od;
    logic            acc_now, out_now, stall;
    int sent, got, cyc, errs;
    sent = 0; got = 0; cyc = 0; errs = 0;
    a = '0; b = '0;
    bus.in_valid = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        a = DW'($urandom); b = DW'($urandom);
        bus.inData_A = a; bus.inData_B = b;
        bus.in_valid = 1'b1;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready && bus.out_valid) begin
        total++; bad++; errs++;
        $display("FAIL rnd_ready_and_valid got=11 want=not both");
      end
      acc_now = bus.in_valid && bus.in_ready;
      out_now = bus.out_valid && bus.out_ready;
      stall   = bus.out_valid && !bus.out_ready;
      od = bus.outData;
      tick();
      cyc++;
      if (acc_now) begin
        exp_q.push_back(ref_mul(a, b));
        sent++;
        bus.in_valid = 1'b0;
      end
      if (stall) begin
        total++; if (bus.out_valid !== 1'b1 || bus.outData !== od) begin bad++; $display("FAIL rnd_stall_hold got=%b/%h want=1/%h", bus.out_valid, bus.outData, od); end
      end
      if (out_now) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_unexpected_output got=%h want=none", od); end
        else if (od !== exp_q[0]) begin bad++; $display("FAIL rnd_product got=%h want=%h", od, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (got !== 1000) begin bad++; $display("FAIL rnd_count got=%0d want=1000", got); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.inData_A  = '0;
    bus.inData_B  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    bus.out_ready = 1'b1;
    repeat (12) tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
